// File: rtl/demux1to2_buf.sv
// -----------------------------------------------------------------------------
// demux1to2_buf
//
// One-input, two-output routing demultiplexer. Each destination has a
// single-entry registered slot (data register plus valid flag).
//
// Handshake (all three channels): a word moves on a rising edge when its
// valid and ready are both 1 in the preceding cycle. Valid never depends on
// ready. inReady is combinational from sel1/sel2, the slot valids and the
// destination readies. It never depends on inValid.
//
// Routing: sel1=1 -> dest 1, else sel2=1 -> dest 2, else the word is
// accepted and discarded.
//
// Optional feature: define DEMUX_DROPCNT_EN to add the 8-bit saturating
// dropCount output, which counts discarded words.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active low
//   inData     in   [N-1:0] source word
//   inValid    in   source offers inData
//   sel1/sel2  in   destination select (sel1 has priority)
//   inReady    out  block accepts the offered word this cycle
//   out1/out2  out  [N-1:0] registered destination data
//   out1Valid/out2Valid  out  slot holds an undelivered word
//   out1Ready/out2Ready  in   destination takes its word this cycle
//   dropCount  out  [7:0] discarded-word count (DEMUX_DROPCNT_EN only)
// -----------------------------------------------------------------------------
module demux1to2_buf #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] inData,
  input  logic         inValid,
  input  logic         sel1,
  input  logic         sel2,
  output logic         inReady,
  output logic [N-1:0] out1,
  output logic         out1Valid,
  input  logic         out1Ready,
  output logic [N-1:0] out2,
  output logic         out2Valid,
  input  logic         out2Ready
`ifdef DEMUX_DROPCNT_EN
  ,
  output logic [7:0]   dropCount
`endif
);

  logic slot1_free;
  logic slot2_free;
  logic accept;
  logic accept1;
  logic accept2;
  logic accept_drop;

  // While reset is held, the slots are treated as already cleared. This lets
  // inReady reflect the post-reset state.
  assign slot1_free = ~(out1Valid & rst) | out1Ready;
  assign slot2_free = ~(out2Valid & rst) | out2Ready;

  always_comb begin
    inReady = 1'b1;
    if (sel1)      inReady = slot1_free;
    else if (sel2) inReady = slot2_free;
  end

  assign accept      = inValid & inReady;
  assign accept1     = accept & sel1;
  assign accept2     = accept & ~sel1 & sel2;
  assign accept_drop = accept & ~sel1 & ~sel2;

  // Slot 1. An accept takes precedence over a delivery, so a word delivered
  // and a word accepted in the same cycle sustain full throughput.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out1      <= '0;
      out1Valid <= 1'b0;
    end else if (accept1) begin
      out1      <= inData;
      out1Valid <= 1'b1;
    end else if (out1Ready) begin
      out1Valid <= 1'b0;
    end
  end

  // Slot 2, independent of slot 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out2      <= '0;
      out2Valid <= 1'b0;
    end else if (accept2) begin
      out2      <= inData;
      out2Valid <= 1'b1;
    end else if (out2Ready) begin
      out2Valid <= 1'b0;
    end
  end

`ifdef DEMUX_DROPCNT_EN
  // Saturating count of words accepted with no destination selected.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dropCount <= '0;
    end else if (accept_drop && dropCount != 8'hFF) begin
      dropCount <= dropCount + 8'd1;
    end
  end
`else
  // accept_drop only drives the optional counter.
  logic unused_drop;
  assign unused_drop = accept_drop;
`endif

endmodule
